// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 scheduler constants, FSM encoding and block type
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int AES_BLK_W = 128;
  localparam int AES_RK_IDX_W = 4;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;
  typedef logic [0:AES_BLK_W-1] blk_t;
endpackage

// File: rtl/aes_round_sched_if.sv
// aes_round_sched_if: block I/O handshakes plus round-datapath and key-store bus of the scheduler
interface aes_round_sched_if #(
  parameter int RK_IDX_W = aes_pkg::AES_RK_IDX_W
);
  import aes_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_mode;
  blk_t in_block;
  logic [RK_IDX_W-1:0] rk_idx;
  blk_t rk;
  blk_t rd_state;
  logic rd_mode;
  logic rd_final;
  blk_t rd_result;
  logic out_valid;
  logic out_ready;
  blk_t out_block;
  modport master (
    output in_valid, in_mode, in_block, rk, rd_result, out_ready,
    input in_ready, rk_idx, rd_state, rd_mode, rd_final, out_valid, out_block
  );
  modport slave (
    input in_valid, in_mode, in_block, rk, rd_result, out_ready,
    output in_ready, rk_idx, rd_state, rd_mode, rd_final, out_valid, out_block
  );
endinterface

// File: rtl/aes_round_sched.sv
// aes_round_sched: iterative AES-128 round scheduler (clk, rst_n, bus slave, busy); AES_DECRYPT_EN enables reversed-key decrypt
module aes_round_sched #(
  parameter int NR = aes_pkg::AES_NR,
  parameter int RK_IDX_W = aes_pkg::AES_RK_IDX_W
) (
  input logic clk,
  input logic rst_n,
  aes_round_sched_if.slave bus,
  output logic busy
);
  import aes_pkg::*;
`ifdef AES_DECRYPT_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif
  localparam logic [RK_IDX_W-1:0] NR_W = RK_IDX_W'(NR);
  fsm_e st_q, st_d;
  blk_t state_q, state_d;
  logic [RK_IDX_W-1:0] rnd_q, rnd_d;
  logic mode_q, mode_d, mode_in, last;
  assign mode_in = bus.in_mode & DEC_EN;
  assign last = rnd_q == NR_W;
  assign bus.in_ready = st_q == IDLE;
  assign bus.out_valid = st_q == DONE;
  assign bus.out_block = state_q;
  assign bus.rd_state = state_q;
  assign bus.rd_mode = mode_q;
  assign bus.rd_final = st_q == ROUND && last;
  assign bus.rk_idx = st_q == IDLE ? (mode_in ? NR_W : '0) : st_q == ROUND ? (mode_q ? NR_W - rnd_q : rnd_q) : '0;
  assign busy = st_q != IDLE;
  always_comb begin
    st_d = st_q;
    state_d = state_q;
    rnd_d = rnd_q;
    mode_d = mode_q;
    if (st_q == IDLE && bus.in_valid) begin
      st_d = ROUND;
      state_d = bus.in_block ^ bus.rk;
      rnd_d = RK_IDX_W'(1);
      mode_d = mode_in;
    end else if (st_q == ROUND) begin
      st_d = last ? DONE : ROUND;
      state_d = bus.rd_result;
      rnd_d = last ? rnd_q : rnd_q + 1'b1;
    end else if (st_q == DONE && bus.out_ready) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      state_q <= '0;
      rnd_q <= '0;
      mode_q <= MODE_ENC;
    end else begin
      st_q <= st_d;
      state_q <= state_d;
      rnd_q <= rnd_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: table-driven FIPS-197 checks of the round scheduler with key-expansion and round-datapath models
module tb_aes_round_sched;
  import aes_pkg::*;
`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  typedef struct {
    logic [127:0] key;
    logic mode;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;
  logic clk;
  logic rst_n;
  logic busy;
  logic [127:0] rks [16];
  int checks = 0;
  int failures = 0;
  aes_round_sched_if bus ();
  aes_round_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a, p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gm(sq, sq);
      r = gm(r, sq);
    end
    return r;
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] v;
    v = ginv(x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] x, input bit inv);
    logic [7:0] m [4];
    logic [7:0] col [4];
    logic [7:0] acc;
    logic [127:0] y;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) col[j] = x[127-8*(4*c+j) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(m[(j-r+4)%4], col[j]);
        y[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return y;
  endfunction
  function automatic logic [127:0] rnd_fn(input logic [127:0] s, input logic [127:0] k, input logic m, input logic fin);
    logic [127:0] t;
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = m ? isb(s[127-8*((i%4)+4*(((i/4)+4-(i%4))%4)) -: 8])
                          : sb(s[127-8*((i%4)+4*(((i/4)+(i%4))%4)) -: 8]);
    if (!m) return (fin ? t : mix(t, 1'b0)) ^ k;
    t = t ^ k;
    return fin ? t : mix(t, 1'b1);
  endfunction
  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rks[0];
    for (int r = 1; r <= 10; r++) s = rnd_fn(s, rks[r], 1'b0, r == 10);
    return s;
  endfunction
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[r] = r <= 10 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask
  assign bus.rk = rks[bus.rk_idx];
  assign bus.rd_result = rnd_fn(bus.rd_state, bus.rk, bus.rd_mode, bus.rd_final);
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int lat;
    bit dec;
    dec = v.mode & DEC_EN;
    expand(v.key);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode = v.mode;
    bus.in_block = v.blk;
    bus.out_ready = 1'b1;
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_rk_idx", bus.rk_idx, dec ? 10 : 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk("round_rk_idx", bus.rk_idx, dec ? 10 - lat : lat);
      chk("round_rd_final", bus.rd_final, lat == 10);
      chk("round_rd_mode", bus.rd_mode, dec);
      chk("round_busy", busy, 1);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 11);
    chk("out_block", bus.out_block, v.exp);
    @(negedge clk);
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_busy", busy, 0);
  endtask
  vec_t tbl [5];
  logic [127:0] pts [3];
  logic [127:0] exps [3];
  int acc_c [3];
  int k_in, k_out, n;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{K1, 1'b0, PT1, CT1};
    tbl[1] = '{128'h0, 1'b0, 128'h0, CT0};
    tbl[2] = '{K2, 1'b0, PT2, CT2};
`ifdef AES_DECRYPT_EN
    tbl[3] = '{K1, 1'b1, CT1, PT1};
    tbl[4] = '{K2, 1'b1, CT2, PT2};
`else
    tbl[3] = '{K1, 1'b1, PT1, CT1};
    tbl[4] = '{K2, 1'b1, PT2, CT2};
`endif
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_block = '0;
    bus.out_ready = 1'b0;
    expand(K1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_rd_final", bus.rd_final, 0);
    chk("rst_rk_idx", bus.rk_idx, 0);
    chk("rst_rd_state", bus.rd_state, 0);
    chk("rst_rd_mode", bus.rd_mode, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    expand(K1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode = 1'b0;
    bus.in_block = PT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_block = PT2;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_block", bus.out_block, CT1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    chk("bp_hold_valid", bus.out_valid, 1);
    chk("bp_hold_block", bus.out_block, CT1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_out_valid", bus.out_valid, 0);
    chk("bp_rel_in_ready", bus.in_ready, 1);
    chk("bp_rel_busy", busy, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_block = PT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_rk_idx", bus.rk_idx, 5);
    chk("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_rd_state", bus.rd_state, 0);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(tbl[0]);
    expand(K1);
    pts[0] = PT1;
    pts[1] = 128'h0;
    pts[2] = '1;
    exps[0] = CT1;
    exps[1] = ref_enc(pts[1]);
    exps[2] = ref_enc(pts[2]);
    bus.in_mode = 1'b0;
    bus.out_ready = 1'b1;
    k_in = 0;
    k_out = 0;
    for (int c = 0; c < 80 && k_out < 3; c++) begin
      @(negedge clk);
      bus.in_block = pts[k_in < 3 ? k_in : 0];
      bus.in_valid = k_in < 3;
      if (bus.out_valid) begin
        chk("b2b_out_block", bus.out_block, exps[k_out]);
        k_out++;
      end
      if (bus.in_ready && bus.in_valid) begin
        acc_c[k_in] = c;
        k_in++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_results", k_out, 3);
    chk("b2b_accepts", k_in, 3);
    chk("b2b_gap1", acc_c[1] - acc_c[0], 12);
    chk("b2b_gap2", acc_c[2] - acc_c[1], 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
